// File: rtl/sst_seq.sv
// Save-state sequencer: walks the sst register space for host save (read) and restore (write) commands.
// Latency: first byte WAIT+1 cycles after accept; per byte WAIT+1 (save) or WAIT+2 (restore) cycles minimum.
// Backpressure: rd_ready low holds XFER with rd_data stable; wr_valid low holds XFER; abort ends the op with err.
module sst_seq #(
    parameter int WAIT = 2
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [6:0] cmd_first,
    input  logic [6:0] cmd_last,
    input  logic       abort,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic       sst_we_reg,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_XFER,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(WAIT - 1);
    // Address 127 holds the read-only mapper index; restores must not write it.
    localparam logic [6:0] RO_ADDR     = 7'h7F;

    state_t     state;
    state_t     state_nxt;
    logic       op_q;
    logic [6:0] last_q;
    logic [6:0] addr_q;
    logic [3:0] cnt_q;
    logic [7:0] rd_data_q;
    logic [7:0] dato_q;
    logic       err_q;

    logic       cmd_acc;
    logic       cmd_bad;
    logic       at_last;
    logic       settle_end;
    logic       rd_hs;
    logic       wr_hs;
    logic       advance;

    assign sst_addr = {1'b0, addr_q};
    assign sst_dato = dato_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;

    // Next-state decode and all combinational outputs; abort masks handshakes and the write strobe.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        sst_act    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        rd_valid   = 1'b0;
        wr_ready   = 1'b0;
        sst_we_reg = 1'b0;
        cmd_acc    = 1'b0;
        rd_hs      = 1'b0;
        wr_hs      = 1'b0;
        advance    = 1'b0;
        cmd_bad    = (cmd_first > cmd_last);
        at_last    = (addr_q == last_q);
        settle_end = (cnt_q == SETTLE_LAST);
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                cmd_acc   = cmd_valid;
                if (cmd_valid && !cmd_bad) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                sst_act = 1'b1;
                busy    = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (settle_end) begin
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                sst_act  = 1'b1;
                busy     = 1'b1;
                rd_valid = !op_q && !abort;
                wr_ready = op_q && !abort;
                rd_hs    = rd_valid && rd_ready;
                wr_hs    = wr_ready && wr_valid;
                advance  = rd_hs;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (wr_hs) begin
                    state_nxt = S_WRITE;
                end else if (rd_hs) begin
                    state_nxt = at_last ? S_DONE : S_SETTLE;
                end
            end
            S_WRITE: begin
                sst_act    = 1'b1;
                busy       = 1'b1;
                sst_we_reg = !abort && (addr_q != RO_ADDR);
                advance    = !abort;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = at_last ? S_DONE : S_SETTLE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch, address walk, settle counter, data capture and error pulse.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            op_q      <= 1'b0;
            last_q    <= 7'd0;
            addr_q    <= 7'd0;
            cnt_q     <= 4'd0;
            rd_data_q <= 8'd0;
            dato_q    <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            err_q <= (cmd_acc && cmd_bad) || (sst_act && abort);
            if (cmd_acc) begin
                op_q   <= cmd_op;
                last_q <= cmd_last;
            end
            // The address only moves on SETTLE entry, so a rejected command leaves it alone.
            if (cmd_acc && !cmd_bad) begin
                addr_q <= cmd_first;
                cnt_q  <= 4'd0;
            end
            if (state == S_SETTLE) begin
                cnt_q <= cnt_q + 4'd1;
                if (settle_end && !op_q && !abort) begin
                    rd_data_q <= sst_di;
                end
            end
            // The last address ends the walk, so the 7-bit address never wraps.
            if (advance && !at_last) begin
                addr_q <= addr_q + 7'd1;
                cnt_q  <= 4'd0;
            end
            if (wr_hs) begin
                dato_q <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_sst_seq.sv
// Bench for sst_seq: mapper model sst_di = addr^0x5A, scoreboard queues for strobes and save bytes.
// Latency: checks first-byte and first-strobe cycle offsets and save byte period for WAIT=2.
// Backpressure: exercises rd_ready stall, random wr_valid gaps, abort and mid-op reset.
module tb_sst_seq;

    localparam int WAIT = 2;

    logic       clk = 1'b0;
    logic       map_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [6:0] cmd_first;
    logic [6:0] cmd_last;
    logic       abort;
    logic       sst_act;
    logic [7:0] sst_addr;
    logic       sst_we_reg;
    logic [7:0] sst_dato;
    logic [7:0] sst_di;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    assign sst_di = sst_addr ^ 8'h5A;

    sst_seq #(.WAIT(WAIT)) dut (
        .clk        (clk),
        .map_rst    (map_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_first  (cmd_first),
        .cmd_last   (cmd_last),
        .abort      (abort),
        .sst_act    (sst_act),
        .sst_addr   (sst_addr),
        .sst_we_reg (sst_we_reg),
        .sst_dato   (sst_dato),
        .sst_di     (sst_di),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    logic [31:0] outs;
    assign outs = {cmd_ready, sst_act, sst_addr, sst_we_reg, sst_dato, rd_data,
                   rd_valid, wr_ready, busy, done, err};
    localparam logic [31:0] OUTS_RESET = 32'h8000_0000;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_cmd;
    int first_rd_cyc;
    int first_we_cyc;
    int err_cyc;
    int we_cnt;
    int rd_cnt;
    int wr_cnt;
    int done_cnt;
    int err_cnt;
    int act_cnt;
    logic [15:0] exp_we_q[$];
    logic [7:0]  exp_rd_q[$];
    int          rd_cyc_q[$];

    always @(posedge clk) cyc++;

    // Scoreboard monitor: compares every strobe and every save byte against the expected queues.
    always @(negedge clk) begin : mon
        logic [15:0] ew;
        logic [7:0]  er;
        if (sst_we_reg === 1'b1) begin
            we_cnt++;
            if (first_we_cyc < 0) first_we_cyc = cyc;
            checks++;
            if (exp_we_q.size() == 0) begin
                errors++;
                $display("FAIL we_strobe: unexpected strobe addr=%h dato=%h", sst_addr, sst_dato);
            end else begin
                ew = exp_we_q.pop_front();
                if ({sst_addr, sst_dato} !== ew || sst_act !== 1'b1) begin
                    errors++;
                    $display("FAIL we_strobe: got addr=%h dato=%h act=%b, want addr=%h dato=%h act=1",
                             sst_addr, sst_dato, sst_act, ew[15:8], ew[7:0]);
                end
            end
        end
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            rd_cnt++;
            rd_cyc_q.push_back(cyc);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_byte: unexpected byte %h", rd_data);
            end else begin
                er = exp_rd_q.pop_front();
                if (rd_data !== er) begin
                    errors++;
                    $display("FAIL rd_byte: got %h, want %h", rd_data, er);
                end
            end
        end
        if (wr_valid === 1'b1 && wr_ready === 1'b1) wr_cnt++;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) begin
            err_cnt++;
            if (err_cyc < 0) err_cyc = cyc;
        end
        if (sst_act === 1'b1) act_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        first_rd_cyc = -1;
        first_we_cyc = -1;
        err_cyc      = -1;
        we_cnt       = 0;
        rd_cnt       = 0;
        wr_cnt       = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        act_cnt      = 0;
        exp_we_q.delete();
        exp_rd_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic issue_cmd(input logic op, input logic [6:0] first, input logic [6:0] last);
        tick();
        cmd_op    = op;
        cmd_first = first;
        cmd_last  = last;
        cmd_valid = 1'b1;
        t_cmd     = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: cmd_ready=%b after %0d cycles, want 1", name, cmd_ready, n);
        end
    endtask

    // Drives restore bytes base+i until stop_hs handshakes are seen; returns at the negedge
    // just before the last handshake edge.
    task automatic drive_restore(input int stop_hs, input logic [7:0] base, input bit gaps);
        int i = 0;
        int n = 0;
        while (i < stop_hs && n < 500) begin
            wr_data  = base + 8'(i);
            wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (wr_valid && wr_ready) i++;
            if (i < stop_hs) tick();
            n++;
        end
        checks++;
        if (i != stop_hs) begin
            errors++;
            $display("FAIL restore_drive: handshakes=%0d, want %0d", i, stop_hs);
        end
    endtask

    task automatic test_reset();
        map_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs !== OUTS_RESET) begin
            errors++;
            $display("FAIL reset_in: outputs=%h, want %h", outs, OUTS_RESET);
        end
        tick();
        map_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== OUTS_RESET) begin
            errors++;
            $display("FAIL reset_after: outputs=%h, want %h", outs, OUTS_RESET);
        end
    endtask

    task automatic test_save_range();
        bit per_ok;
        clear_stats();
        for (int k = 8; k <= 13; k++) exp_rd_q.push_back(8'(k) ^ 8'h5A);
        rd_ready = 1'b1;
        issue_cmd(1'b0, 7'd8, 7'd13);
        wait_idle("save", 200);
        rd_ready = 1'b0;
        checks++;
        if (rd_cnt != 6 || exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL save_count: bytes=%0d left=%0d, want 6 and 0", rd_cnt, exp_rd_q.size());
        end
        checks++;
        if (first_rd_cyc - t_cmd != WAIT + 1) begin
            errors++;
            $display("FAIL save_latency: %0d cycles, want %0d", first_rd_cyc - t_cmd, WAIT + 1);
        end
        per_ok = (rd_cyc_q.size() == 6);
        for (int k = 1; k < rd_cyc_q.size(); k++)
            if (rd_cyc_q[k] - rd_cyc_q[k-1] != WAIT + 1) per_ok = 1'b0;
        checks++;
        if (!per_ok) begin
            errors++;
            $display("FAIL save_period: byte spacing not %0d cycles (n=%0d)", WAIT + 1, rd_cyc_q.size());
        end
        checks++;
        if (done_cnt != 1 || err_cnt != 0 || sst_act !== 1'b0) begin
            errors++;
            $display("FAIL save_done: done=%0d err=%0d act=%b, want 1 0 0", done_cnt, err_cnt, sst_act);
        end
    endtask

    task automatic test_restore_gaps();
        clear_stats();
        for (int k = 0; k < 8; k++) exp_we_q.push_back({8'(k), 8'h10 + 8'(k)});
        issue_cmd(1'b1, 7'd0, 7'd7);
        drive_restore(8, 8'h10, 1'b1);
        tick();
        wr_valid = 1'b0;
        wait_idle("restore", 200);
        checks++;
        if (we_cnt != 8 || exp_we_q.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL restore_count: strobes=%0d left=%0d done=%0d, want 8 0 1",
                     we_cnt, exp_we_q.size(), done_cnt);
        end
    endtask

    task automatic test_restore_top();
        clear_stats();
        exp_we_q.push_back({8'd126, 8'hA0});
        issue_cmd(1'b1, 7'd126, 7'd127);
        drive_restore(2, 8'hA0, 1'b0);
        tick();
        wr_valid = 1'b0;
        wait_idle("restore_top", 100);
        checks++;
        if (we_cnt != 1 || wr_cnt != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL restore_top: strobes=%0d consumed=%0d done=%0d, want 1 2 1",
                     we_cnt, wr_cnt, done_cnt);
        end
        checks++;
        if (first_we_cyc - t_cmd != WAIT + 2) begin
            errors++;
            $display("FAIL restore_latency: %0d cycles, want %0d", first_we_cyc - t_cmd, WAIT + 2);
        end
    endtask

    task automatic test_save_stall();
        logic [7:0] held;
        bit hold_ok = 1'b1;
        int n = 0;
        clear_stats();
        exp_rd_q.push_back(8'h7F ^ 8'h5A);
        rd_ready = 1'b0;
        issue_cmd(1'b0, 7'd127, 7'd127);
        @(negedge clk);
        while (rd_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = rd_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rd_data !== held || rd_valid !== 1'b1) hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok || held !== 8'h25) begin
            errors++;
            $display("FAIL stall_hold: rd_data=%h held=%h ok=%b, want 25 held", rd_data, held, hold_ok);
        end
        tick();
        rd_ready = 1'b1;
        wait_idle("stall", 50);
        rd_ready = 1'b0;
        checks++;
        if (rd_cnt != 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_done: bytes=%0d done=%0d, want 1 1", rd_cnt, done_cnt);
        end
    endtask

    task automatic test_reject();
        clear_stats();
        issue_cmd(1'b0, 7'd9, 7'd8);
        repeat (4) @(negedge clk);
        checks++;
        if (err_cnt != 1 || err_cyc - t_cmd != 1) begin
            errors++;
            $display("FAIL reject_err: pulses=%0d offset=%0d, want 1 1", err_cnt, err_cyc - t_cmd);
        end
        checks++;
        if (act_cnt != 0 || done_cnt != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reject_quiet: act=%0d done=%0d ready=%b, want 0 0 1", act_cnt, done_cnt, cmd_ready);
        end
    endtask

    task automatic test_abort();
        clear_stats();
        for (int k = 0; k <= 10; k++) exp_we_q.push_back({8'(k), 8'h30 + 8'(k)});
        issue_cmd(1'b1, 7'd0, 7'd10);
        drive_restore(4, 8'h30, 1'b0);
        tick();
        wr_valid = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        checks++;
        if (sst_we_reg !== 1'b0 || sst_act !== 1'b1 || sst_addr !== 8'd3) begin
            errors++;
            $display("FAIL abort_strobe: we=%b act=%b addr=%h, want 0 1 03", sst_we_reg, sst_act, sst_addr);
        end
        tick();
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, sst_act, busy, done, err, sst_we_reg} !== 6'b100010) begin
            errors++;
            $display("FAIL abort_next: ready/act/busy/done/err/we=%b, want 100010",
                     {cmd_ready, sst_act, busy, done, err, sst_we_reg});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (we_cnt != 3 || err_cnt != 1 || done_cnt != 0 || exp_we_q.size() != 8) begin
            errors++;
            $display("FAIL abort_count: strobes=%0d err=%0d done=%0d left=%0d, want 3 1 0 8",
                     we_cnt, err_cnt, done_cnt, exp_we_q.size());
        end
    endtask

    task automatic test_reset_midop();
        clear_stats();
        for (int k = 0; k <= 10; k++) exp_we_q.push_back({8'(k), 8'h40 + 8'(k)});
        issue_cmd(1'b1, 7'd0, 7'd10);
        drive_restore(2, 8'h40, 1'b0);
        tick();
        wr_valid = 1'b0;
        map_rst  = 1'b1;
        tick();
        map_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== OUTS_RESET) begin
            errors++;
            $display("FAIL midop_reset: outputs=%h, want %h", outs, OUTS_RESET);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt != 0 || done_cnt != 0 || cmd_ready !== 1'b1 || sst_act !== 1'b0) begin
            errors++;
            $display("FAIL midop_quiet: err=%0d done=%0d ready=%b act=%b, want 0 0 1 0",
                     err_cnt, done_cnt, cmd_ready, sst_act);
        end
    endtask

    initial begin
        map_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_first = 7'd0;
        cmd_last  = 7'd0;
        abort     = 1'b0;
        rd_ready  = 1'b0;
        wr_data   = 8'd0;
        wr_valid  = 1'b0;
        clear_stats();
        test_reset();
        test_save_range();
        test_restore_gaps();
        test_restore_top();
        test_save_stall();
        test_reject();
        test_abort();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
